// File: rtl/dsp_mac_pkg.sv
// Shared OPMODE decode, X/Z select codes and per-stage control payload for dsp_mac_pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dsp_mac_pkg;

    localparam int OP_X_LSB    = 0;
    localparam int OP_Z_LSB    = 2;
    localparam int OP_PRE_EN   = 4;
    localparam int OP_CIN      = 5;
    localparam int OP_PRE_SUB  = 6;
    localparam int OP_POST_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    // Only the OPMODE bits still needed after the pre-adder travel down the pipe.
    typedef struct packed {
        logic   vld;
        logic   post_sub;
        logic   cin;
        z_sel_e z_sel;
        x_sel_e x_sel;
    } stage_ctl_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Enable-gated pipeline register with asynchronous active-low clear.
// Latency: 1 cycle when en is high.
// Backpressure: holds its contents while en is low.
module dsp_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-add / multiply / post-add-accumulate slice with per-beat OPMODE; DSP_MAC_SAT_EN saturates P.
// Latency: 3 register stages from accept to OUT_VALID; 1 result per cycle when OUT_READY stays high.
// Backpressure: whole pipe stalls when OUT_VALID && !OUT_READY; IN_READY = !OUT_VALID | OUT_READY.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int C_W = 48
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [A_W-1:0]     A,
    input  logic [B_W-1:0]     B,
    input  logic [B_W-1:0]     D,
    input  logic [C_W-1:0]     C,
    input  logic [C_W-1:0]     PCIN,
    input  logic [7:0]         OPMODE,
    input  logic               ACC_CLR,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [C_W-1:0]     P,
    output logic [C_W-1:0]     PCOUT,
    output logic [A_W+B_W-1:0] M,
    output logic               CARRYOUT
);

    localparam int M_W   = A_W + B_W;
    localparam int CTL_W = $bits(stage_ctl_t);
    localparam int S_W   = CTL_W + A_W + B_W + C_W + B_W;

    logic             adv;
    stage_ctl_t       ctl_in, s1_ctl, s2_ctl;
    logic [B_W-1:0]   b_pre, s1_b, s2_b, s1_d, s2_d;
    logic [A_W-1:0]   s1_a, s2_a;
    logic [C_W-1:0]   s1_c, s2_c;
    logic [S_W-1:0]   s1_q, s2_q;
    logic [M_W-1:0]   m_nxt, m_q;
    logic [C_W-1:0]   p_q, p_fb, x_val, z_val, p_res;
    logic             carry_q, ov_q;
    logic [C_W:0]     r, pc_d, pc_q;

    assign adv      = !ov_q || OUT_READY;
    assign IN_READY = adv;

    always_comb begin
        ctl_in          = '0;
        ctl_in.vld      = IN_VALID;
        ctl_in.post_sub = OPMODE[OP_POST_SUB];
        ctl_in.cin      = OPMODE[OP_CIN];
        ctl_in.z_sel    = z_sel_e'(OPMODE[OP_Z_LSB +: 2]);
        ctl_in.x_sel    = x_sel_e'(OPMODE[OP_X_LSB +: 2]);
    end

    assign b_pre = !OPMODE[OP_PRE_EN] ? B :
                   (OPMODE[OP_PRE_SUB] ? D - B : D + B);

    // Stage 1: operands, pre-adder result and control
    dsp_pipe_reg #(.WIDTH(S_W)) u_s1 (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (adv),
        .d     ({ctl_in, A, b_pre, C, D}),
        .q     (s1_q)
    );
    assign {s1_ctl, s1_a, s1_b, s1_c, s1_d} = s1_q;

    assign m_nxt = M_W'(s1_a) * M_W'(s1_b);

    // Stage 2: operands travel alongside the product; M only moves on a valid beat
    dsp_pipe_reg #(.WIDTH(S_W)) u_s2 (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (adv),
        .d     (s1_q),
        .q     (s2_q)
    );
    assign {s2_ctl, s2_a, s2_b, s2_c, s2_d} = s2_q;

    dsp_pipe_reg #(.WIDTH(M_W)) u_m (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (adv && s1_ctl.vld),
        .d     (m_nxt),
        .q     (m_q)
    );

    // Stage 3: X/Z muxes and post-adder; ACC_CLR zeroes the feedback for the entering beat
    always_comb begin
        p_fb  = ACC_CLR ? '0 : p_q;
        x_val = '0;
        z_val = '0;
        case (s2_ctl.x_sel)
            X_ZERO: x_val = '0;
            X_M:    x_val = C_W'(m_q);
            X_P:    x_val = p_fb;
            X_DAB:  x_val = C_W'({s2_d, s2_a, s2_b});
            default: x_val = '0;
        endcase
        case (s2_ctl.z_sel)
            Z_ZERO: z_val = '0;
            Z_PCIN: z_val = PCIN;
            Z_P:    z_val = p_fb;
            Z_C:    z_val = s2_c;
            default: z_val = '0;
        endcase
        if (s2_ctl.post_sub) begin
            r = {1'b0, z_val} - ({1'b0, x_val} + {{C_W{1'b0}}, s2_ctl.cin});
        end else begin
            r = {1'b0, z_val} + {1'b0, x_val} + {{C_W{1'b0}}, s2_ctl.cin};
        end
`ifdef DSP_MAC_SAT_EN
        if (r[C_W]) begin
            p_res = s2_ctl.post_sub ? '0 : '1;
        end else begin
            p_res = r[C_W-1:0];
        end
`else
        p_res = r[C_W-1:0];
`endif
        pc_d = s2_ctl.vld ? {r[C_W], p_res} : '0;
    end

    dsp_pipe_reg #(.WIDTH(C_W+1)) u_p (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (adv && (s2_ctl.vld || ACC_CLR)),
        .d     (pc_d),
        .q     (pc_q)
    );
    assign {carry_q, p_q} = pc_q;

    dsp_pipe_reg #(.WIDTH(1)) u_ov (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (adv),
        .d     (s2_ctl.vld),
        .q     (ov_q)
    );

    assign OUT_VALID = ov_q;
    assign P         = p_q;
    assign PCOUT     = p_q;
    assign M         = m_q;
    assign CARRYOUT  = carry_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed self-checking bench for dsp_mac_pipe with hand-computed expected values.
module tb_dsp_mac_pipe;

    logic        CLK;
    logic        RST_N;
    logic [17:0] A, B, D;
    logic [47:0] C, PCIN;
    logic [7:0]  OPMODE;
    logic        ACC_CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [47:0] P, PCOUT;
    logic [35:0] M;
    logic        CARRYOUT;

    int total = 0;
    int bad   = 0;

    logic        col_en = 1'b0;
    logic [47:0] got_q[$];
    logic        drv_ok, seen;
    logic [47:0] g;

    dsp_mac_pipe u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .A         (A),
        .B         (B),
        .D         (D),
        .C         (C),
        .PCIN      (PCIN),
        .OPMODE    (OPMODE),
        .ACC_CLR   (ACC_CLR),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .P         (P),
        .PCOUT     (PCOUT),
        .M         (M),
        .CARRYOUT  (CARRYOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (col_en && OUT_VALID && OUT_READY) got_q.push_back(P);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                          input logic [47:0] c, input logic [7:0] op);
        A = a; B = b; D = d; C = c; OPMODE = op;
    endtask

    // one beat offered for one edge, then withdrawn
    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                        input logic [47:0] c, input logic [7:0] op);
        set_in(a, b, d, c, op);
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; A = '0; B = '0; D = '0; C = '0; PCIN = '0; OPMODE = '0;
        ACC_CLR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        step(); step();
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_p", P, 0);
        check("rst_m", M, 0);
        check("rst_carry", CARRYOUT, 0);
        check("rst_in_ready", IN_READY, 1);
        RST_N = 1'b1;
        step();

        // simple multiply with latency check
        send(3, 4, 0, 0, 8'h01);
        check("mul_lat_early", OUT_VALID, 0);
        step();
        check("mul_lat_mid", OUT_VALID, 0);
        step();
        check("mul_valid", OUT_VALID, 1);
        check("mul_p", P, 12);
        check("mul_pcout", PCOUT, 12);
        check("mul_m", M, 12);
        check("mul_carry", CARRYOUT, 0);
        step();
        check("mul_valid_drop", OUT_VALID, 0);
        check("mul_p_hold", P, 12);

        send(2, 4, 10, 0, 8'h51);
        step(); step();
        check("presub_m", M, 12);
        check("presub_p", P, 12);

        send(3, 4, 10, 0, 8'h11);
        step(); step();
        check("preadd_m", M, 42);
        check("preadd_p", P, 42);

        // {D,A,B} truncated to 48 bits: D bit 12 falls off the top
        send(2, 3, 18'h01001, 0, 8'h03);
        step(); step();
        check("dab_p", P, 48'h0010_0008_0003);
        check("dab_m", M, 6);

        send(2, 3, 0, 5, 8'h8D);
        step(); step();
`ifdef DSP_MAC_SAT_EN
        check("borrow_p", P, 48'h0);
`else
        check("borrow_p", P, 48'hFFFF_FFFF_FFFF);
`endif
        check("borrow_carry", CARRYOUT, 1);

        PCIN = 48'hFFFF_FFFF_FFFF;
        send(1, 1, 0, 0, 8'h25);
        step(); step();
`ifdef DSP_MAC_SAT_EN
        check("carry_p", P, 48'hFFFF_FFFF_FFFF);
`else
        check("carry_p", P, 1);
`endif
        check("carry_co", CARRYOUT, 1);
        PCIN = '0;

        // idle clear
        ACC_CLR = 1'b1;
        step();
        ACC_CLR = 1'b0;
        check("clr_p", P, 0);
        check("clr_carry", CARRYOUT, 0);

        // three back-to-back accumulates
        set_in(5, 5, 0, 0, 8'h09);
        IN_VALID = 1'b1;
        step(); step(); step();
        IN_VALID = 1'b0;
        check("acc_p0", P, 25);
        step();
        check("acc_p1", P, 50);
        step();
        check("acc_p2", P, 75);
        step();
        check("acc_idle_valid", OUT_VALID, 0);
        check("acc_idle_p", P, 75);

        ACC_CLR = 1'b1;
        step();
        ACC_CLR = 1'b0;
        check("clr2_p", P, 0);

        // ACC_CLR coincides with the third beat entering stage 3
        IN_VALID = 1'b1;
        step(); step(); step();
        IN_VALID = 1'b0;
        check("accclr_p0", P, 25);
        step();
        check("accclr_p1", P, 50);
        ACC_CLR = 1'b1;
        step();
        ACC_CLR = 1'b0;
        check("accclr_p2", P, 25);
        step();

        // back-pressure: stall output for 4 cycles after the first result
        got_q.delete();
        col_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    set_in(18'(i + 1), 7, 0, 0, 8'h01);
                    IN_VALID = 1'b1;
                    drv_ok = 1'b0;
                    for (int w = 0; w < 40 && !drv_ok; w++) begin
                        @(negedge CLK);
                        if (IN_READY) drv_ok = 1'b1;
                    end
                    check("bp_accept", drv_ok, 1);
                    step();
                end
                IN_VALID = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int w = 0; w < 40 && !seen; w++) begin
                    @(posedge CLK);
                    #2;
                    if (OUT_VALID) seen = 1'b1;
                end
                check("bp_first_valid", seen, 1);
                OUT_READY = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge CLK);
                    #2;
                    check("bp_stall_in_ready", IN_READY, 0);
                    check("bp_hold_valid", OUT_VALID, 1);
                    check("bp_hold_p", P, 7);
                    check("bp_hold_m", M, 14);
                end
                OUT_READY = 1'b1;
            end
        join
        for (int k = 0; k < 8; k++) step();
        col_en = 1'b0;
        check("bp_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 48'hFFFF_FFFF_FFFF;
            check("bp_order", g, 64'((i + 1) * 7));
        end

        // reset with two beats in flight
        set_in(9, 9, 0, 0, 8'h01);
        IN_VALID = 1'b1;
        step();
        set_in(1, 2, 0, 0, 8'h01);
        step();
        IN_VALID = 1'b0;
        check("pre_rst_m", M, 81);
        #3;
        RST_N = 1'b0;
        #1;
        check("midrst_valid", OUT_VALID, 0);
        check("midrst_p", P, 0);
        check("midrst_m", M, 0);
        check("midrst_carry", CARRYOUT, 0);
        step();
        RST_N = 1'b1;
        check("midrst_in_ready", IN_READY, 1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("midrst_no_stale", OUT_VALID, 0);
        end
        check("midrst_p_after", P, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, handshaked successor to the fixed-width DSP slice. It is a three-stage pipelined pre-add / multiply / post-add-accumulate datapath. Each transaction carries its own OPMODE through the pipeline with the data, so the mode can change on every beat. A valid/ready handshake on both sides provides full back-pressure. The block sits between operand producers and downstream filter/accumulator logic. Slices chain through PCIN/PCOUT.

## Interface
Parameters:
- A_W, 18, width of A.
- B_W, 18, width of B, D and the pre-adder result.
- C_W, 48, width of C, PCIN, P and PCOUT. Must satisfy C_W ≥ A_W+B_W.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A  in  A_W  multiplier operand.
- B  in  B_W  pre-adder operand (second input).
- D  in  B_W  pre-adder operand (first input).
- C  in  C_W  Z-mux operand.
- PCIN  in  C_W  cascade input from the previous slice.
- OPMODE  in  8  per-transaction mode; sampled with the data.
- ACC_CLR  in  1  accumulator clear; see Operation.
- IN_VALID  in  1  an input transaction is offered.
- IN_READY  out  1  the block accepts the offered transaction.
- OUT_VALID  out  1  P/CARRYOUT hold a completed result.
- OUT_READY  in  1  downstream consumes the result.
- P  out  C_W  accumulator/result register.
- PCOUT  out  C_W  equal to P.
- M  out  A_W+B_W  stage-2 product register.
- CARRYOUT  out  1  carry/borrow of the last result.

## Operation
- OPMODE fields:
  - [1:0] X select: 0 → 0; 1 → M zero-extended; 2 → P; 3 → {D,A,B} truncated/zero-extended to C_W.
  - [3:2] Z select: 0 → 0; 1 → PCIN; 2 → P; 3 → C.
  - [4] pre-adder enable.
  - [5] carry-in.
  - [6] pre-subtract.
  - [7] post-subtract.
- All arithmetic is unsigned and modulo the stated width.
- Stage 1 registers A, C, D, OPMODE and B'. B' = OPMODE[4] ? (OPMODE[6] ? D−B : D+B) mod 2^B_W : B.
- Stage 2 registers M = A×B' (A_W+B_W bits). C, D, A and OPMODE travel alongside M.
- Stage 3 computes R = OPMODE[7] ? Z−(X+CIN) : Z+X+CIN at C_W+1 bits.
  - P ← R[C_W−1:0].
  - CARRYOUT ← R[C_W], which is the borrow when subtracting.
- P feedback uses the current P register, so back-to-back accumulates are exact.
- Each stage has a valid bit. The whole pipeline advances when adv = !OUT_VALID | OUT_READY.
  - IN_READY = adv.
  - A transfer occurs when IN_VALID & IN_READY.
- When adv is low, every stage holds, including P, M and CARRYOUT.
- A bubble (no transfer) inserts an invalid stage. Invalid stages never update P, CARRYOUT or M.
- ACC_CLR behaviour:
  - If a valid transaction enters stage 3 in the same cycle, that transaction uses P = 0 for its X/Z feedback.
  - Otherwise P ← 0 and CARRYOUT ← 0 when adv is high.
  - ACC_CLR is ignored while stalled.
- OUT_VALID rises when a valid transaction completes stage 3. It clears when the result is consumed and no new result completes in the same cycle.

## Timing
- Latency is 3 cycles from the accept edge to OUT_VALID high, with no stall.
- Throughput is 1 transaction per cycle when OUT_READY is held high.
- Reset (asynchronous, RST_N low) clears all of the following immediately: stage valids, OUT_VALID, P, PCOUT, M, CARRYOUT and all pipeline registers.
- Reset mid-operation drops all in-flight transactions. IN_READY is 1 after reset.
- IN_READY depends combinationally on OUT_VALID and OUT_READY only. It does not depend on IN_VALID.
- OUT_VALID and P are registered outputs.

## Configuration
- DSP_MAC_SAT_EN defined: stage 3 saturates the result.
  - Add overflow (carry set) gives P ← all ones.
  - Subtract borrow gives P ← 0.
  - CARRYOUT still reports the raw carry/borrow.
- DSP_MAC_SAT_EN undefined: P wraps modulo 2^C_W.

## Structure
- Package dsp_mac_pkg holds:
  - OPMODE bit-index localparams.
  - The X/Z select enumerations (typedefs for the 2-bit codes).
  - The stage-payload struct type.
- One sub-module, dsp_pipe_reg, implements the enable-gated pipeline register with async active-low clear. It is parametrised by WIDTH and instantiated per stage.

## Test plan
- Simple multiply: A=3, B=4, OPMODE=8'h01, OUT_READY=1 → P=12 and M=12 three cycles after accept; CARRYOUT=0.
- Pre-subtract: D=10, B=4, A=2, OPMODE=8'h51 → B'=6, M=12, P=12.
- Accumulate: three transactions A=B=5, OPMODE=8'h09 back-to-back → P=25, 50, 75 on consecutive cycles. Repeat with ACC_CLR on the third transaction → P=25, 50, 25.
- Borrow: C=5, A=2, B=3, OPMODE=8'h8D →
  - without the macro: P=2^48−1, CARRYOUT=1;
  - with DSP_MAC_SAT_EN: P=0, CARRYOUT=1.
- Back-pressure:
  - Stimulus: five back-to-back inputs with OUT_READY held low for 4 cycles after the first OUT_VALID.
  - Required: IN_READY is low throughout the stall and the pipeline holds.
  - Required: all five results are delivered in order, with none lost or duplicated.
- Reset mid-stream: assert RST_N low with two transactions in flight → OUT_VALID=0 and P=0 immediately. No stale result appears after RST_N is released.
